image_vector_fetcher: RTL
=========================

// Module: image_vector_fetcher
// PURPOSE
// - Sequencer and arbiter for the 8-pixel combinational image data-memory read port.
// - Streams num_vec consecutive 8-pixel vectors from base_addr to the vector pipeline over a valid/ready output.
// - Shares the single memory address port with CPU scalar/vector loads (cpu_*).
// - Sits between the data memory and the vector register-file load path.
// PARAMETERS
// - IMAGE_WIDTH   96  pixels per row
// - IMAGE_HEIGHT  96  rows; MEM_DEPTH = IMAGE_WIDTH*IMAGE_HEIGHT = 9216 bytes
// - PIX_SIZE      8   bits per pixel
// - LANES         8   pixels per vector fetch; address step per fetch
// - STARVE_LIMIT  4   consecutive CPU grants before the fetcher is forced one grant
// PORTS
// - CLK        in   1             clock, rising edge
// - RST        in   1             asynchronous reset, active-high
// - start      in   1             1-cycle launch strobe; ignored unless state==IDLE
// - base_addr  in   16            byte address of first vector
// - num_vec    in   12            vectors to stream; 0 is legal
// - busy       out  1             state!=IDLE
// - done       out  1             1-cycle pulse, end of job (normal, empty or error)
// - err        out  1             sticky bounds error; cleared on next accepted start
// - mem_addr   out  16            address driven to data memory
// - mem_rd     in   16x16         memory read lanes; lane i = pixel at mem_addr+i in bits [PIX_SIZE-1:0]
// - cpu_req    in   1             CPU wants the port this cycle
// - cpu_addr   in   16            CPU address
// - cpu_gnt    out  1             CPU owns port this cycle (comb.)
// - cpu_rdata  out  16x16         mem_rd passthrough; valid only when cpu_gnt
// - out_valid  out  1             output vector register holds data
// - out_ready  in   1             consumer accepts when out_valid&&out_ready
// - out_data   out  LANESxPIX_SIZE  registered vector, lane 0 = lowest address
// - out_last   out  1             qualifies final vector of job
// - stall_cnt  out  16            statistics, see CONFIGURATION
// BEHAVIOUR
// - Reset: state=IDLE; busy, done, err, out_valid, out_last = 0; out_data = 0; cur_addr = 0; remaining = 0; starve = 0; stall_cnt = 0.
// - FSM IDLE->RUN on start with num_vec!=0: latch cur_addr=base_addr, remaining=num_vec; clear err.
// - FSM IDLE->DONE on start with num_vec==0: no fetch, no output.
// - RUN: fetcher wants the port when remaining!=0 and (!out_valid || out_ready).
// - Bounds: if a wanted fetch has cur_addr+LANES > MEM_DEPTH (17-bit compare), set err, go DONE, drop remaining vectors.
//   Data already in the output register still drains normally.
// - RUN->DONE when remaining==0 and the final vector has been accepted.
// - DONE: done=1 for exactly 1 cycle, then IDLE. busy is 0 in the cycle after DONE.
// - Arbitration (comb.): cpu_gnt = cpu_req && !(fetch_want && starve==STARVE_LIMIT).
//   Fetcher is granted when fetch_want && !cpu_gnt.
//   mem_addr = cpu_gnt ? cpu_addr : cur_addr.
// - starve counter: increments on cpu_gnt while fetch_want; clears on a fetcher grant or !fetch_want; saturates at STARVE_LIMIT.
// - Fetcher grant registers mem_rd[i][PIX_SIZE-1:0] into out_data lane i, sets out_valid=1 and out_last=(remaining==1), then cur_addr+=LANES and remaining-=1.
// - Latency: start at cycle t, no CPU traffic -> RUN at t+1 -> out_valid at t+2. Sustains 1 vector/cycle while out_ready=1.
// - Simultaneous out accept and new grant in the same cycle: register reloads and out_valid stays 1.
// - Accept with no grant: out_valid->0.
// - A start that arrives while busy is ignored, including during DONE.
// - Asynchronous RST mid-job aborts immediately to reset values. The pending vector is lost, and done is not pulsed.
// CONFIGURATION
// - Macro FETCH_STATS_EN defined: stall_cnt counts cycles where fetch_want && !fetcher_granted, plus cycles where out_valid && !out_ready.
//   stall_cnt saturates at 16'hFFFF and clears on each accepted start.
// - Macro FETCH_STATS_EN undefined: stall_cnt tied to 16'h0 and no counter logic is built. The port list is identical either way.
// STRUCTURE
// - Package vfetch_pkg holds the state enum typedef {IDLE,RUN,DONE}, LANES, MEM_DEPTH, STARVE_LIMIT and a vec_t typedef (LANES x PIX_SIZE).
// - Sub-module vfetch_arbiter: 2-way CPU-priority arbiter with starvation counter.
//   Inputs cpu_req, fetch_want; outputs cpu_gnt, fetch_gnt.
// - FSM, address/count datapath and output register live in image_vector_fetcher.
// TESTING
// - start base=0,num_vec=3, out_ready=1, no CPU -> out_valid cycles t+2..t+4.
//   Data from addresses 0,8,16; out_last on third; done at t+5.
// - num_vec=0 start -> done pulse at t+1, out_valid never set, err=0.
// - base=9208,num_vec=2 -> first vector from 9208 delivered; second fetch fails 9216+8>9216.
//   err=1, done pulses, only 1 vector out with out_last=0.
// - cpu_req held high during a 4-vector job -> cpu_gnt on 4 cycles, then fetcher granted once, repeating.
//   Job completes; cpu_rdata matches cpu_addr contents whenever cpu_gnt.
// - out_ready=0 for 5 cycles mid-job -> out_data held stable and no mem fetch.
//   With FETCH_STATS_EN, stall_cnt==5.
// - RST asserted with remaining=2 -> all outputs 0 asynchronously; a new start afterwards runs cleanly.

Source files
------------

// File: rtl/vfetch_pkg.sv
// Shared types and constants for the image vector fetcher: FSM states, memory
// geometry, vector layout and the fetch bounds check.
package vfetch_pkg;

    localparam int IMAGE_WIDTH  = 96;
    localparam int IMAGE_HEIGHT = 96;
    localparam int PIX_SIZE     = 8;
    localparam int LANES        = 8;
    localparam int MEM_DEPTH    = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int STARVE_LIMIT = 4;
    localparam int STARVE_W     = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef logic [LANES-1:0][PIX_SIZE-1:0] vec_t;

    // 17-bit sum so a vector starting near the top of the 16-bit space cannot wrap.
    function automatic logic out_of_bounds(input logic [15:0] addr);
        return ({1'b0, addr} + 17'(LANES)) > 17'(MEM_DEPTH);
    endfunction

endpackage

// File: rtl/vfetch_arbiter.sv
// Two-way arbiter for the data-memory port: CPU has priority, but the fetcher
// is forced one grant after STARVE_LIMIT consecutive CPU wins while it waits.
module vfetch_arbiter
    import vfetch_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    input  logic cpu_req,
    input  logic fetch_want,
    output logic cpu_gnt,
    output logic fetch_gnt
);

    logic [STARVE_W-1:0] starve;

    assign cpu_gnt   = cpu_req && !(fetch_want && (starve == STARVE_W'(STARVE_LIMIT)));
    assign fetch_gnt = fetch_want && !cpu_gnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            starve <= '0;
        end else if (!fetch_want || fetch_gnt) begin
            starve <= '0;
        end else if (cpu_gnt && (starve != STARVE_W'(STARVE_LIMIT))) begin
            starve <= starve + 1'b1;
        end
    end

endmodule

// File: rtl/image_vector_fetcher.sv
// Streams num_vec 8-pixel vectors from base_addr over a valid/ready output while
// sharing the memory port with CPU loads. Define FETCH_STATS_EN to build stall_cnt.
module image_vector_fetcher
    import vfetch_pkg::*;
(
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      start,
    input  logic [15:0]               base_addr,
    input  logic [11:0]               num_vec,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [15:0]               mem_addr,
    input  logic [15:0][15:0]         mem_rd,
    input  logic                      cpu_req,
    input  logic [15:0]               cpu_addr,
    output logic                      cpu_gnt,
    output logic [15:0][15:0]         cpu_rdata,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*PIX_SIZE-1:0] out_data,
    output logic                      out_last,
    output logic [15:0]               stall_cnt
);

    state_t      state;
    logic [15:0] cur_addr;
    logic [11:0] remaining;
    vec_t        out_vec;
    logic        want_raw;
    logic        oob;
    logic        fetch_want;
    logic        fetch_gnt;
    logic        slot_free;

    assign slot_free  = !out_valid || out_ready;
    assign want_raw   = (state == RUN) && (remaining != 12'd0) && slot_free;
    // A fetch that would run past the end of memory never competes for the port.
    assign oob        = want_raw && out_of_bounds(cur_addr);
    assign fetch_want = want_raw && !oob;

    vfetch_arbiter u_arb (
        .CLK        (CLK),
        .RST        (RST),
        .cpu_req    (cpu_req),
        .fetch_want (fetch_want),
        .cpu_gnt    (cpu_gnt),
        .fetch_gnt  (fetch_gnt)
    );

    assign mem_addr  = cpu_gnt ? cpu_addr : cur_addr;
    assign cpu_rdata = mem_rd;
    assign out_data  = out_vec;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cur_addr  <= '0;
            remaining <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        err  <= 1'b0;
                        busy <= 1'b1;
                        if (num_vec == 12'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= RUN;
                            cur_addr  <= base_addr;
                            remaining <= num_vec;
                        end
                    end
                end
                RUN: begin
                    if (fetch_gnt) begin
                        cur_addr  <= cur_addr + 16'(LANES);
                        remaining <= remaining - 12'd1;
                    end
                    if (oob) begin
                        err       <= 1'b1;
                        remaining <= '0;
                        state     <= DONE;
                        done      <= 1'b1;
                    end else if ((remaining == 12'd0) && slot_free) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Output register drains independently of the FSM, so it empties even after an abort.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_vec   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (fetch_gnt) begin
            for (int i = 0; i < LANES; i++) begin
                out_vec[i] <= mem_rd[i][PIX_SIZE-1:0];
            end
            out_valid <= 1'b1;
            out_last  <= (remaining == 12'd1);
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

`ifdef FETCH_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_q <= '0;
        end else if ((state == IDLE) && start) begin
            stall_q <= '0;
        end else if (((fetch_want && !fetch_gnt) || (out_valid && !out_ready)) &&
                     (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0;
`endif

endmodule
